// File: rtl/mesh_nic.sv
// Network interface between a processing element and a mesh router PE port.
// Optional MESH_NIC_STATS_EN adds 16-bit rx/tx packet counters in status bits [31:16].
module mesh_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  input  logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  output logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  typedef enum logic [1:0] {
    REG_IN_BUF   = 2'd0,
    REG_IN_STAT  = 2'd1,
    REG_OUT_BUF  = 2'd2,
    REG_OUT_STAT = 2'd3
  } reg_sel_e;

  reg_sel_e              sel;
  logic [DATA_WIDTH-1:0] in_buf;
  logic [DATA_WIDTH-1:0] out_buf;
  logic                  in_full;
  logic                  out_full;
  logic                  rd_clear;
  logic                  wr_out;
  logic                  eject;
  logic [15:0]           rx_stat;
  logic [15:0]           tx_stat;

  assign sel = reg_sel_e'(addr);

  assign net_ro = ~in_full;
  assign net_do = out_buf;
  // Packets only leave on cycles whose polarity matches their VC.
  assign net_so = out_full & net_ri & (out_buf[VC_BIT] == net_polarity);

  assign rd_clear = nicEn & ~nicWrEn & (sel == REG_IN_BUF) & in_full;
  assign wr_out   = nicEn & nicWrEn & (sel == REG_OUT_BUF) & ~out_full;
  assign eject    = net_si & ~in_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf   <= '0;
      in_full  <= 1'b0;
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      if (eject) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end else if (rd_clear) begin
        in_full <= 1'b0;
      end
      // A write in the injecting cycle sees out_full=1 and is dropped.
      if (wr_out) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end else if (net_so) begin
        out_full <= 1'b0;
      end
    end
  end

`ifdef MESH_NIC_STATS_EN
  logic [15:0] rx_cnt;
  logic [15:0] tx_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (eject)  rx_cnt <= rx_cnt + 16'd1;
      if (net_so) tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign rx_stat = rx_cnt;
  assign tx_stat = tx_cnt;
`else
  assign rx_stat = '0;
  assign tx_stat = '0;
`endif

  always_comb begin
    d_out = '0;
    if (nicEn && !nicWrEn) begin
      unique case (sel)
        REG_IN_BUF:   d_out = in_buf;
        REG_IN_STAT:  begin
          d_out[0]     = in_full;
          d_out[31:16] = rx_stat;
        end
        REG_OUT_BUF:  d_out = out_buf;
        REG_OUT_STAT: begin
          d_out[0]     = out_full;
          d_out[31:16] = tx_stat;
        end
        default:      d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_nic.sv
// Directed self-checking bench for mesh_nic; expected packets are queued when
// driven and popped when the NIC injects them or software reads them back.
module tb_mesh_nic;

`ifdef MESH_NIC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] tx_q[$];
  logic [63:0] rx_q[$];

  localparam logic [63:0] PKT_V1 = 64'hD000_0000_1111_1111;
  localparam logic [63:0] PKT_A  = 64'h8000_0000_AAAA_AAAA;
  localparam logic [63:0] PKT_B  = 64'h8000_0000_BBBB_BBBB;
  localparam logic [63:0] PKT_C  = 64'h8000_0000_CCCC_CCCC;
  localparam logic [63:0] PKT_V0 = 64'h0000_0000_3333_3333;
  localparam logic [63:0] PKT_E1 = 64'h4000_0000_2222_2222;
  localparam logic [63:0] PKT_E2 = 64'h2000_0001_5555_5555;
  localparam logic [63:0] PKT_E3 = 64'h6000_0002_7777_7777;

  mesh_nic #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] st(input logic full, input int unsigned cnt);
    logic [63:0] w;
    w = '0;
    w[0] = full;
    if (STATS) w[31:16] = cnt[15:0];
    return w;
  endfunction

  function automatic logic [63:0] pop_tx();
    if (tx_q.size() == 0) return 'x;
    return tx_q.pop_front();
  endfunction

  function automatic logic [63:0] pop_rx();
    if (rx_q.size() == 0) return 'x;
    return rx_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'd0; d_in = '0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_ri = 1'b0; net_di = '0; net_polarity = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_d_out", d_out, '0);
    chk("reset_net_so", {63'd0, net_so}, 64'd1 - 64'd1);
    chk("reset_net_ro", {63'd0, net_ro}, 64'd1);
    chk("reset_net_do", net_do, '0);
    rd(2'd1); chk("reset_in_stat", d_out, st(1'b0, 0));
    rd(2'd3); chk("reset_out_stat", d_out, st(1'b0, 0));
    idle();

    // vc=1 packet waits for polarity 1
    net_ri = 1'b1; net_polarity = 1'b0;
    wr(2'd2, PKT_V1); tx_q.push_back(PKT_V1);
    tick(); idle(); #1;
    chk("pol0_no_inject", {63'd0, net_so}, 64'd0);
    chk("net_do_held", net_do, PKT_V1);
    tick(); net_polarity = 1'b1; #1;
    chk("pol1_inject_so", {63'd0, net_so}, 64'd1);
    chk("pol1_inject_do", net_do, pop_tx());
    tick(); net_polarity = 1'b0;
    rd(2'd3); chk("out_stat_after_tx1", d_out, st(1'b0, 1));
    idle();

    // back-to-back writes with router blocked: second dropped
    net_ri = 1'b0;
    wr(2'd2, PKT_A); tx_q.push_back(PKT_A);
    tick(); wr(2'd2, PKT_B);
    tick();
    rd(2'd2); chk("out_buf_keeps_first", d_out, PKT_A);
    rd(2'd3); chk("out_stat_full", d_out, st(1'b1, 1));
    chk("blocked_no_inject", {63'd0, net_so}, 64'd0);
    // injection with a same-cycle write: write dropped
    net_ri = 1'b1; net_polarity = 1'b1;
    wr(2'd2, PKT_C); #1;
    chk("tx2_so", {63'd0, net_so}, 64'd1);
    chk("tx2_do", net_do, pop_tx());
    tick();
    rd(2'd3); chk("write_during_inject_dropped", d_out, st(1'b0, 2));
    idle();

    // vc=0 packet goes out on polarity 0
    net_polarity = 1'b0;
    wr(2'd2, PKT_V0); tx_q.push_back(PKT_V0);
    tick(); idle(); #1;
    chk("tx3_so", {63'd0, net_so}, 64'd1);
    chk("tx3_do", net_do, pop_tx());
    tick();
    chk("tx3_done", {63'd0, net_so}, 64'd0);

    // ejection, second arrival ignored while full
    net_si = 1'b1; net_di = PKT_E1; #1;
    chk("ro_before_eject", {63'd0, net_ro}, 64'd1);
    rx_q.push_back(PKT_E1);
    tick(); net_di = PKT_E2;
    rd(2'd1); chk("in_stat_full", d_out, st(1'b1, 1));
    chk("ro_while_full", {63'd0, net_ro}, 64'd0);
    tick(); net_si = 1'b0;
    rd(2'd0); chk("rx1_read", d_out, pop_rx());
    chk("ro_still_low_during_read", {63'd0, net_ro}, 64'd0);
    tick(); idle(); #1;
    chk("ro_after_clear", {63'd0, net_ro}, 64'd1);
    rd(2'd0); chk("stale_read", d_out, PKT_E1);
    tick();
    rd(2'd1); chk("in_stat_after_stale", d_out, st(1'b0, 1));
    chk("ro_after_stale", {63'd0, net_ro}, 64'd1);
    idle();

    net_si = 1'b1; net_di = PKT_E3; rx_q.push_back(PKT_E3);
    tick(); net_si = 1'b0;
    rd(2'd0); chk("rx2_read", d_out, pop_rx());
    tick();
    rd(2'd3); chk("tx_count", d_out, st(1'b0, 3));
    rd(2'd1); chk("rx_count", d_out, st(1'b0, 2));
    idle();

    // reset with both buffers full discards them
    net_ri = 1'b0;
    wr(2'd2, PKT_A);
    tick(); idle();
    net_si = 1'b1; net_di = PKT_E2;
    tick(); net_si = 1'b0;
    rd(2'd1); chk("pre_reset_in_full", d_out, st(1'b1, 3));
    rd(2'd3); chk("pre_reset_out_full", d_out, st(1'b1, 3));
    idle();
    net_ri = 1'b1; net_polarity = 1'b1; reset = 1'b1;
    tick(); reset = 1'b0;
    chk("post_reset_so", {63'd0, net_so}, 64'd0);
    chk("post_reset_ro", {63'd0, net_ro}, 64'd1);
    rd(2'd1); chk("post_reset_in_stat", d_out, st(1'b0, 0));
    rd(2'd3); chk("post_reset_out_stat", d_out, st(1'b0, 0));
    idle();

`ifdef MESH_NIC_STATS_EN
    force dut.rx_cnt = 16'hFFFF;
    #1;
    release dut.rx_cnt;
    rd(2'd1); chk("rx_cnt_forced", d_out, st(1'b0, 16'hFFFF));
    idle();
    net_si = 1'b1; net_di = PKT_E1;
    tick(); net_si = 1'b0;
    rd(2'd1); chk("rx_cnt_wrap", d_out, st(1'b1, 0));
    idle();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mesh_nic.md
# mesh_nic

Network interface controller between a processing element and the PE port of one mesh router. Exposes a two-bit addressed register interface to the processor: one single-entry input channel buffer, one single-entry output channel buffer, and a status register per channel. The router side speaks the PE-port handshake (pesi/pedi/peri and peso/pero/pedo on the router), gated by the router's polarity. One instance sits beside every router in the 2x2 mesh.

## Interface
Parameters:
- DATA_WIDTH, 64, packet and processor data width
- VC_BIT, 63, packet bit carrying the virtual-channel id

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr  in  2  register select: 0 in-buffer, 1 in-status, 2 out-buffer, 3 out-status
- d_in  in  64  processor write data
- d_out  out  64  processor read data (combinational)
- nicEn  in  1  register access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_si  in  1  router has a packet for the PE (router peso)
- net_ri  in  1  router can accept an injected packet (router peri)
- net_di  in  64  packet from router (router pedo)
- net_so  out  1  NIC injects packet (router pesi)
- net_ro  out  1  NIC can accept a packet (router pero)
- net_do  out  64  injected packet (router pedi)
- net_polarity  in  1  router polarity

## Operation
- State: in_buf[63:0], in_full, out_buf[63:0], out_full. All zero on reset.
- Packet format: {vc[63], dir[62:61], rsvd[60:56], hop[55:48], src[47:32], payload[31:0]}; NIC never modifies packets.
- Status word: bit0 = channel full flag; bits[63:1] zero (see Configuration for [31:16]).
- Read (nicEn=1, nicWrEn=0): d_out = in_buf / {..,in_full} / out_buf / {..,out_full} for addr 0/1/2/3. nicEn=0 -> d_out = 0.
- Read of addr 0 with in_full=1 clears in_full at the edge; read of addr 0 with in_full=0 returns stale in_buf, no state change.
- Write (nicEn=1, nicWrEn=1) to addr 2 with out_full=0: out_buf <= d_in, out_full <= 1. With out_full=1: ignored. Writes to addr 0, 1, 3 ignored.
- Ejection: net_ro = ~in_full. When net_si && net_ro at an edge: in_buf <= net_di, in_full <= 1.
- Injection: net_so = out_full && net_ri && (out_buf[VC_BIT] == net_polarity); net_do = out_buf always. At an edge with net_so=1: out_full <= 0.
- Simultaneous processor write to addr 2 and injection in the same cycle: the write sees pre-edge out_full=1 and is dropped; software must poll status.
- Simultaneous read-clear of in_buf and arrival cannot occur (net_ro=0 while full); arrival accepted earliest the cycle after the clear.
- Reset asserted mid-transfer: both buffers empty, net_so=0, net_ro=1 in the cycle after the reset edge; packets in flight are discarded.

## Timing
- Reset values: d_out 0, net_so 0, net_ro 1 (after first reset edge), net_do 0.
- Write-to-inject: earliest net_so in the cycle after the write edge, if net_ri=1 and polarity matches; otherwise held until both hold.
- Eject-to-visible: in-status bit0 reads 1 in the cycle after the accepting edge.
- Sustained rate: one packet per two cycles per direction (polarity gating alone halves injection opportunities).
- All outputs except d_out, net_so are register-driven; net_so combinational from registers, net_ri, net_polarity.

## Configuration
- MESH_NIC_STATS_EN defined: two 16-bit counters, rx_cnt (increments on each accepted ejection) and tx_cnt (each injection), wrap 0xFFFF -> 0x0000, reset to 0. Status bits[31:16] read rx_cnt at addr 1 and tx_cnt at addr 3.
- Undefined: counters absent, status bits[31:16] read 0.

## Test plan
- Reset then idle: d_out=0, net_so=0, net_ro=1, addr 1 and 3 read 0.
- Write addr 2 d_in=0xD000_0000_1111_1111 (vc=1), net_ri=1, polarity toggling: net_so=1 only in the cycle with polarity=1, net_do equals written value, addr 3 reads 0 afterwards.
- Write addr 2 twice back-to-back with net_ri=0: second write dropped, out_buf keeps first value, out-status=1.
- Router drives net_si=1, net_di=0x4000_0000_2222_2222: in-status=1, net_ro=0; second net_si packet ignored; read addr 0 returns 0x4000_0000_2222_2222, next cycle net_ro=1.
- Reset asserted with both buffers full: next cycle both statuses 0, net_so=0, net_ro=1.
- With MESH_NIC_STATS_EN: 3 injections and 2 ejections -> addr 3 bits[31:16]=3, addr 1 bits[31:16]=2; force rx_cnt to 0xFFFF then one ejection -> 0.
